clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider / tick generator for game timing (mole pop-up rate, display refresh, debounce, countdown).
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe from the single system clock.
- Each channel's divisor can be rewritten at run time. The change takes effect glitch-free at that channel's next terminal count.
- Each channel has its own enable and synchronous phase clear.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 25, width of each channel's counter and divisor.
- DEF_DIV, 2499999, divisor loaded into every channel at reset. Must fit in CNT_W.
- SEL_W, 2, width of div_sel. Must be at least max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  NUM_CH  per-channel count enable.
- phase_clr  in  NUM_CH  per-channel synchronous restart.
- div_wr  in  1  divisor write strobe, one cycle.
- div_sel  in  SEL_W  channel addressed by div_wr.
- div_data  in  CNT_W  new divisor value.
- div_pend  out  NUM_CH  bit i high = channel i holds an unapplied divisor.
- clk_d  out  NUM_CH  divided clock per channel.
- tick  out  NUM_CH  one-cycle strobe per channel at each terminal count.

Behaviour:
- **Per-channel state:** count[CNT_W], div_cur[CNT_W], div_new[CNT_W], pend, clk_d, tick. All registered, no combinational outputs.
- **Reset** (rst_n=0 at a rising edge), overriding everything:
  - count=0, div_cur=DEF_DIV, div_new=0, pend=0, clk_d=0, tick=0.
  - Reset mid-operation discards pending writes.
- **Per-channel priority each edge** (rst_n=1): phase_clr, then en, then hold.
- **phase_clr[i]=1:**
  - count=0, clk_d=0, tick=0.
  - If pend: div_cur=div_new and pend=0.
  - Takes effect regardless of en.
- **en[i]=1, count==div_cur (terminal):**
  - count=0, clk_d toggles, tick=1 for exactly the following cycle.
  - If pend: div_cur=div_new and pend=0.
- **en[i]=1, otherwise:** count=count+1, tick=0.
- **en[i]=0:** count, clk_d and div_cur hold; tick=0. Resuming continues from the held count with no lost or extra cycles.
- **Timing:** tick period = div_cur+1 cycles. clk_d period = 2*(div_cur+1) cycles, exact 50% duty. tick rises on the same edge clk_d toggles.
- **div_cur = 0:** terminal on every enabled edge. tick stays high continuously and clk_d toggles every cycle (clk/2).
- **Divisor write** (div_wr=1, div_sel<NUM_CH): div_new[div_sel]=div_data and pend=1 at that edge.
  - div_sel >= NUM_CH: the write is ignored, no state changes.
  - Write while pend already set: div_new is overwritten (last write wins) and pend stays 1.
  - Write on the same edge as that channel's terminal or phase_clr:
    - the terminal/clear uses the pre-edge div_new/pend;
    - the new value is captured into div_new with pend=1;
    - it applies at the following terminal/clear.
  - Write to a disabled channel stays pending until its next terminal or phase_clr.
- **Independence:** channels never interact. A write or clear to one channel does not perturb any other.
- **Arithmetic:** unsigned. count never exceeds div_cur, so no wrap-around is possible.

Test Plan:

Bench configuration: NUM_CH=2, CNT_W=8, DEF_DIV=3, SEL_W=1.

1. **Reset then default divide:** release rst_n, en=2'b11.
   - tick[0] and tick[1] high for one cycle on the 4th, 8th, 12th enabled edges.
   - clk_d rises at edge 4, falls at edge 8 (period 8).
2. **Runtime write:** div_wr, sel=0, data=1 at edge 2 after reset.
   - div_pend=2'b01 until edge 4, then clears.
   - ch0 ticks every 2 cycles with clk_d period 4; ch1 stays at period 8.
3. **Divisor 0 and collision:**
   - Write 0 to ch1 on the same edge as its terminal: old divisor runs one more period, then ch1 switches.
   - ch1 then gives clk_d toggling every cycle and tick constantly 1.
4. **Enable hold:** drop en[0] at count=2 for 5 cycles, then re-raise.
   - No tick and clk_d unchanged while disabled.
   - Next tick exactly 2 enabled edges after re-enable.
5. **Phase clear with pending:** write 5 to ch0, then pulse phase_clr[0] before the terminal.
   - Next edge: count=0, clk_d=0, div_pend[0]=0.
   - Ticks then arrive every 6 cycles.
6. **Reset mid-operation and bad select:**
   - div_wr with sel=1 while ch1 pending, then rst_n=0 for one edge: all outputs 0, div_pend=0, divisors back to 3.
   - With NUM_CH=3 and sel=3: no pend bit set.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel emits a 50%-duty divided
// clock and a one-cycle tick at every terminal count, with run-time divisor updates.
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 25,
  parameter int DEF_DIV = 2499999,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] phase_clr,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] div_pend,
  output logic [NUM_CH-1:0] clk_d,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

  // div_wr is a single-cycle strobe with no back-pressure: it is always accepted
  // on the edge where it is high, and addresses outside 0..NUM_CH-1 are dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_div_new;
    logic             r_pend;
    logic             r_clk_d;
    logic             r_tick;
    logic             w_term;
    logic             w_apply;
    logic             w_wr_hit;

    assign w_term   = (r_count == r_div_cur);
    assign w_apply  = phase_clr[gi] || (en[gi] && w_term);
    assign w_wr_hit = div_wr && (div_sel == SEL_W'(gi));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_count   <= '0;
        r_div_cur <= DEF_DIV_V;
        r_div_new <= '0;
        r_pend    <= 1'b0;
        r_clk_d   <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        if (phase_clr[gi]) begin
          r_count <= '0;
          r_clk_d <= 1'b0;
          r_tick  <= 1'b0;
        end else if (en[gi]) begin
          if (w_term) begin
            r_count <= '0;
            r_clk_d <= ~r_clk_d;
            r_tick  <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
            r_tick  <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
        end

        // The apply point sees the pre-edge div_new/pend; a coincident write lands
        // in div_new and waits for the next terminal or clear.
        if (w_apply && r_pend) begin
          r_div_cur <= r_div_new;
        end
        if (w_wr_hit) begin
          r_div_new <= div_data;
          r_pend    <= 1'b1;
        end else if (w_apply) begin
          r_pend    <= 1'b0;
        end
      end
    end

    assign div_pend[gi] = r_pend;
    assign clk_d[gi]    = r_clk_d;
    assign tick[gi]     = r_tick;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: two-channel divider with default divisor 3,
// plus a three-channel instance to exercise an out-of-range divisor select.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en;
  logic [1:0] phase_clr;
  logic       div_wr;
  logic [0:0] div_sel;
  logic [7:0] div_data;
  logic [1:0] div_pend;
  logic [1:0] clk_d;
  logic [1:0] tick;

  logic [2:0] en3;
  logic [2:0] phase_clr3;
  logic       div_wr3;
  logic [1:0] div_sel3;
  logic [7:0] div_data3;
  logic [2:0] div_pend3;
  logic [2:0] clk_d3;
  logic [2:0] tick3;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  always #5 clk = ~clk;

  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(3), .SEL_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
    .div_pend(div_pend), .clk_d(clk_d), .tick(tick)
  );

  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .phase_clr(phase_clr3),
    .div_wr(div_wr3), .div_sel(div_sel3), .div_data(div_data3),
    .div_pend(div_pend3), .clk_d(clk_d3), .tick(tick3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default divisor 3: tick on every 4th enabled edge, clk_d toggles with it.
  function automatic logic t4(input int k);
    return (k % 4) == 0;
  endfunction

  function automatic logic c4(input int k);
    return ((k / 4) % 2) == 1;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 2'b00;
    phase_clr = 2'b00;
    div_wr    = 1'b0;
    step();
    step();
    check("rst clk_d", clk_d, 2'b00);
    check("rst tick", tick, 2'b00);
    check("rst pend", div_pend, 2'b00);
    rst_n = 1'b1;
    en    = 2'b11;
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = '0;
    phase_clr  = '0;
    div_wr     = 1'b0;
    div_sel    = '0;
    div_data   = '0;
    en3        = '0;
    phase_clr3 = '0;
    div_wr3    = 1'b0;
    div_sel3   = '0;
    div_data3  = '0;

    // Reset then default divide
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back({c4(k), c4(k), t4(k), t4(k)});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      e = exp_q.pop_front();
      check($sformatf("t1 clk_d k=%0d", k), clk_d, e[3:2]);
      check($sformatf("t1 tick k=%0d", k), tick, e[1:0]);
    end

    // Runtime write of divisor 1 to ch0 at edge 2
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("t2 tick k=%0d", k), tick,
            {t4(k), (k >= 4) && (k % 2 == 0)});
      check($sformatf("t2 clk_d k=%0d", k), clk_d,
            {c4(k), (k >= 4) && (((k - 4) / 2) % 2 == 0)});
      check($sformatf("t2 pend k=%0d", k), div_pend,
            (k == 2 || k == 3) ? 2'b01 : 2'b00);
      if (k == 1) begin
        div_wr = 1'b1; div_sel = 1'b0; div_data = 8'd1;
      end else if (k == 2) begin
        div_wr = 1'b0;
      end
    end

    // Divisor 0 written to ch1 on its terminal edge 4
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("t3 tick k=%0d", k), tick,
            {(k >= 8) ? 1'b1 : t4(k), t4(k)});
      check($sformatf("t3 clk_d k=%0d", k), clk_d,
            {(k >= 8) ? (k % 2 == 1) : c4(k), c4(k)});
      check($sformatf("t3 pend k=%0d", k), div_pend,
            (k >= 4 && k <= 7) ? 2'b10 : 2'b00);
      if (k == 3) begin
        div_wr = 1'b1; div_sel = 1'b1; div_data = 8'd0;
      end else if (k == 4) begin
        div_wr = 1'b0;
      end
    end

    // ch0 disabled at count 2 for edges 3..7
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("t4 tick k=%0d", k), tick, {t4(k), (k == 9) || (k == 13)});
      check($sformatf("t4 clk_d k=%0d", k), clk_d, {c4(k), (k >= 9) && (k <= 12)});
      if (k == 2) en = 2'b10;
      else if (k == 7) en = 2'b11;
    end

    // Write 5 to ch0 at edge 2, phase clear at edge 3
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      step();
      check($sformatf("t5 tick k=%0d", k), tick,
            {t4(k), (k == 9) || (k == 15) || (k == 21)});
      check($sformatf("t5 clk_d k=%0d", k), clk_d,
            {c4(k), ((k >= 9) && (k <= 14)) || (k >= 21)});
      check($sformatf("t5 pend k=%0d", k), div_pend, (k == 2) ? 2'b01 : 2'b00);
      if (k == 1) begin
        div_wr = 1'b1; div_sel = 1'b0; div_data = 8'd5;
      end else if (k == 2) begin
        div_wr = 1'b0; phase_clr = 2'b01;
      end else if (k == 3) begin
        phase_clr = 2'b00;
      end
    end

    // Reset mid-operation with ch1 pending; out-of-range select on dut3
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) begin
        check("t6 pend first", div_pend, 2'b10);
        check("t6 bad sel", div_pend3, 3'b000);
      end
      if (k == 6) begin
        check("t6 pend overwrite", div_pend, 2'b10);
        check("t6 clk_d pre rst", clk_d, 2'b11);
        check("t6 good sel", div_pend3, 3'b100);
      end
      if (k == 4) begin
        div_wr  = 1'b1; div_sel  = 1'b1;  div_data  = 8'd7;
        div_wr3 = 1'b1; div_sel3 = 2'd3;  div_data3 = 8'd1;
      end else if (k == 5) begin
        div_data = 8'd9;
        div_sel3 = 2'd2;
      end else if (k == 6) begin
        div_wr  = 1'b0;
        div_wr3 = 1'b0;
        rst_n   = 1'b0;
      end
    end
    step();
    check("t6 rst clk_d", clk_d, 2'b00);
    check("t6 rst tick", tick, 2'b00);
    check("t6 rst pend", div_pend, 2'b00);
    check("t6 rst pend3", div_pend3, 3'b000);
    rst_n = 1'b1;
    en    = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("t6 tick k=%0d", k), tick, {t4(k), t4(k)});
      check($sformatf("t6 clk_d k=%0d", k), clk_d, {c4(k), c4(k)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
